// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Imported by the interface, the synchroniser and the FSM top.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int PRESS_CNT_W     = 8;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button pin and conditioned outputs bundled for the light controller.
// master = conditioner side, slave = consumer/driver side.
interface button_conditioner_if;
  import button_pkg::*;

  logic                   btn_raw;
  logic                   press_pulse;
  logic                   release_pulse;
  logic                   btn_level;
  logic [PRESS_CNT_W-1:0] press_cnt;
  logic                   long_pulse;

  modport master (
    input  btn_raw,
    output press_pulse,
    output release_pulse,
    output btn_level,
    output press_cnt,
    output long_pulse
  );

  modport slave (
    output btn_raw,
    input  press_pulse,
    input  release_pulse,
    input  btn_level,
    input  press_cnt,
    input  long_pulse
  );

endinterface

// File: rtl/button_conditioner_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// Legal depth is 2..3; the chain clears to 0 on reset.
module sync_ff #(
  parameter int SYNC_STAGES = button_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronise + debounce a push button into press/release/long pulses.
// Long-press detection is built only with BUTTON_CONDITIONER_LONG_PRESS_EN.
//
// state       | meaning
// IDLE        | button released and stable
// PRESS_CHK   | input high, waiting for it to stay high DEBOUNCE_CYCLES
// HELD        | press accepted; long-press timer runs here
// RELEASE_CHK | input low, waiting for it to stay low DEBOUNCE_CYCLES
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  button_conditioner_if.master bus
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

  btn_state_t             state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic                   press_q,     press_d;
  logic                   release_q,   release_d;
  logic                   level_q,     level_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.btn_raw),
    .q_o   (btn_s)
  );

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  logic long_q,  long_d;
  logic fired_q, fired_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_cnt_d = press_cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    long_d      = 1'b0;
    fired_d     = fired_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          press_cnt_d = press_cnt_q + PRESS_CNT_W'(1);
          cnt_d       = '0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
          fired_d     = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        else if (!fired_q) begin
          // counter parks at LONG_LAST once fired; the flag blocks a repeat
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_cnt_q <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_cnt_q <= press_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      level_q     <= level_d;
    end
  end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q  <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      long_q  <= long_d;
      fired_q <= fired_d;
    end
  end

  assign bus.long_pulse = long_q;
`else
  assign bus.long_pulse = 1'b0;
`endif

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.btn_level     = level_q;
  assign bus.press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/long timings.
// Stimulus pushes expected pulse events; a negedge monitor pops and checks them.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int SS   = 2;
  localparam int LAT  = SS + 1 + DEB;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_kind_t;
  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  ev_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   press_seen = 0;
  int   exp_cnt    = 0;

  button_conditioner_if bus ();

  button_conditioner #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  // expectation only; btn_raw is assumed already high or about to be driven
  task automatic expect_press();
    exp_cnt = (exp_cnt + 1) % 256;
    push_ev(EV_PRESS, cyc + LAT, exp_cnt);
  endtask

  task automatic do_press();
    expect_press();
    bus.btn_raw = 1'b1;
  endtask

  task automatic do_release();
    push_ev(EV_RELEASE, cyc + LAT, exp_cnt);
    bus.btn_raw = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor
  initial begin
    int   np;
    int   act_kind;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        np = int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.long_pulse);
        if (np > 1) check("pulse_exclusive", np, 1);
        if (np > 0) begin
          if (bus.press_pulse) press_seen++;
          act_kind = bus.press_pulse ? EV_PRESS : (bus.release_pulse ? EV_RELEASE : EV_LONG);
          if (sb.size() == 0) begin
            check("unexpected_pulse_kind", act_kind, -1);
          end else begin
            e = sb.pop_front();
            check("event_kind", act_kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_press_cnt", int'(bus.press_cnt), e.cnt);
            check("event_btn_level", int'(bus.btn_level), (act_kind == EV_RELEASE) ? 0 : 1);
          end
        end
      end
    end
  end

  initial begin
    bus.btn_raw = 1'b0;
    rst_n = 1'b0;
    wait_neg(3);
    check("rst_press_pulse",   int'(bus.press_pulse),   0);
    check("rst_release_pulse", int'(bus.release_pulse), 0);
    check("rst_btn_level",     int'(bus.btn_level),     0);
    check("rst_press_cnt",     int'(bus.press_cnt),     0);
    check("rst_long_pulse",    int'(bus.long_pulse),    0);
    rst_n = 1'b1;
    wait_neg(2);

    // clean press held long enough for a long-press, then clean release
    do_press();
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    push_ev(EV_LONG, cyc + LAT + LONG, exp_cnt);
`endif
    wait_neg(40);
    check("s1_level_held", int'(bus.btn_level), 1);
    check("s1_press_cnt",  int'(bus.press_cnt), 1);
    do_release();
    wait_neg(12);
    check("s1_level_released", int'(bus.btn_level), 0);

    // short glitches never reach the debounce limit
    bus.btn_raw = 1'b1; wait_neg(2);
    bus.btn_raw = 1'b0; wait_neg(1);
    bus.btn_raw = 1'b1; wait_neg(2);
    bus.btn_raw = 1'b0; wait_neg(12);
    check("s2_level", int'(bus.btn_level), 0);
    check("s2_press_cnt", int'(bus.press_cnt), exp_cnt);

    // press, release bounce rejected, final release 7 edges after last drop
    do_press();
    wait_neg(10);
    bus.btn_raw = 1'b0; wait_neg(2);
    bus.btn_raw = 1'b1; wait_neg(3);
    check("s3_level_during_bounce", int'(bus.btn_level), 1);
    do_release();
    wait_neg(12);
    check("s3_press_cnt", int'(bus.press_cnt), 2);

    // reset while held
    do_press();
    wait_neg(12);
    check("s5_level_before_rst", int'(bus.btn_level), 1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_press_pulse",   int'(bus.press_pulse),   0);
    check("s5_rst_release_pulse", int'(bus.release_pulse), 0);
    check("s5_rst_btn_level",     int'(bus.btn_level),     0);
    check("s5_rst_press_cnt",     int'(bus.press_cnt),     0);
    check("s5_rst_long_pulse",    int'(bus.long_pulse),    0);
    wait_neg(1);
    rst_n = 1'b1;
    exp_cnt = 0;
    press_seen = 0;
    expect_press();
    wait_neg(10);
    check("s5_press_cnt_after", int'(bus.press_cnt), 1);
    do_release();
    wait_neg(12);

    // 255 more presses wrap the 8-bit counter back to 0
    for (int i = 0; i < 255; i++) begin
      do_press();
      wait_neg(9);
      do_release();
      wait_neg(9);
    end
    wait_neg(5);
    check("s6_press_cnt_wrap", int'(bus.press_cnt), 0);
    check("s6_press_pulses",   press_seen, 256);
    check("scoreboard_left",   sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
